// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Sequential restoring shift-subtract divider. One quotient bit is produced
// per clock, so a normal operation takes WIDTH cycles from the accepting edge
// to the done pulse. A zero divisor is detected at acceptance and answered
// after a single cycle. Results are held until the next operation's done.
//
// Optional feature macro:
//   SEQ_DIV_SIGNED_EN - two's-complement signed operands and results.
//                       Magnitudes are divided, and signs are applied on the
//                       done cycle. The quotient truncates toward zero.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while busy=0
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  last accepted operation had divisor=0
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             accept_zero;
  logic             last_step;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_trial;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] ds_mag;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and one-cycle control strobes for the datapath.
  // last_step fires on the RUN cycle whose edge brings the counter to 0.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    last_step   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_next = RUN;
            accept     = 1'b1;
          end else begin
            state_next  = ZERO;
            accept_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
          last_step  = 1'b1;
        end
      end
      ZERO: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One restoring step. The partial remainder is WIDTH+1 bits wide, so the
  // shifted value cannot lose a carry when the divisor has its top bit set.
  // A negative trial difference shows up in its MSB.
  always_comb begin
    p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    p_trial = p_shift - {1'b0, dvs_reg};
    if (!p_trial[WIDTH]) begin
      p_next = p_trial;
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      p_next = p_shift;
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Operand magnitudes at capture and sign fix-up of the final result.
  // In signed mode the most-negative value has no positive counterpart in
  // WIDTH bits. Its unsigned pattern is still the correct magnitude, and
  // most-negative / -1 wraps back to most-negative without special casing.
  always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
    dd_mag  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    ds_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    quo_fin = neg_q ? (~q_next + 1'b1) : q_next;
    rem_fin = neg_r ? (~p_next[WIDTH-1:0] + 1'b1) : p_next[WIDTH-1:0];
`else
    dd_mag  = dividend;
    ds_mag  = divisor;
    quo_fin = q_next;
    rem_fin = p_next[WIDTH-1:0];
`endif
  end

  // Datapath and result registers. On a zero-divisor accept, q_reg holds the
  // raw dividend so the ZERO cycle can return it as the remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        p_reg   <= '0;
        q_reg   <= dd_mag;
        dvs_reg <= ds_mag;
        cnt     <= CNT_W'(WIDTH);
`ifdef SEQ_DIV_SIGNED_EN
        neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r   <= dividend[WIDTH-1];
`endif
      end
      if (accept_zero) begin
        q_reg <= dividend;
      end
      if (state == RUN) begin
        p_reg <= p_next;
        q_reg <= q_next;
        cnt   <= cnt - 1'b1;
        if (last_step) begin
          done        <= 1'b1;
          quotient    <= quo_fin;
          remainder   <= rem_fin;
          div_by_zero <= 1'b0;
        end
      end
      if (state == ZERO) begin
        done        <= 1'b1;
        quotient    <= '1;
        remainder   <= q_reg;
        div_by_zero <= 1'b1;
      end
    end
  end

endmodule
